// File: rtl/dcache_bypass_arbiter_if.sv
// Bus bundle between the three data-cache request ports, the bypass arbiter
// and the single-outstanding uncached memory port.
interface dcache_bypass_arbiter_if #(
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned TAG_WIDTH   = 44
);
    logic                              flush_i;
    logic                              flush_ack_o;
    logic                              busy_o;

    logic [2:0]                        req_i;
    logic [2:0][INDEX_WIDTH-1:0]       index_i;
    logic [2:0][TAG_WIDTH-1:0]         tag_i;
    logic [2:0]                        kill_i;
    logic [2:0][1:0]                   size_i;
    logic [63:0]                       st_wdata_i;
    logic [7:0]                        st_be_i;
    logic [2:0]                        gnt_o;
    logic [2:0]                        rvalid_o;
    logic [63:0]                       rdata_o;

    logic                              mem_req_o;
    logic                              mem_gnt_i;
    logic                              mem_we_o;
    logic [63:0]                       mem_addr_o;
    logic [1:0]                        mem_size_o;
    logic [63:0]                       mem_wdata_o;
    logic [7:0]                        mem_be_o;
    logic                              mem_rvalid_i;
    logic [63:0]                       mem_rdata_i;

    // Arbiter view.
    modport slave (
        input  flush_i, req_i, index_i, tag_i, kill_i, size_i, st_wdata_i, st_be_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output flush_ack_o, busy_o, gnt_o, rvalid_o, rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_size_o, mem_wdata_o, mem_be_o
    );

    // Environment view: cache request ports plus the memory adapter.
    modport master (
        output flush_i, req_i, index_i, tag_i, kill_i, size_i, st_wdata_i, st_be_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  flush_ack_o, busy_o, gnt_o, rvalid_o, rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_size_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/dcache_bypass_arbiter.sv
// Arbitrates PTW, LOAD and STORE onto one single-outstanding bypass memory port,
// sequencing grant, tag sample, issue and response, plus kill and flush drain.
module dcache_bypass_arbiter #(
    parameter int unsigned INDEX_WIDTH  = 12,
    parameter int unsigned TAG_WIDTH    = 44,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    dcache_bypass_arbiter_if.slave bus
);
    localparam int unsigned PAD_WIDTH  = 64 - TAG_WIDTH - INDEX_WIDTH;
    localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [1:0]  PORT_PTW   = 2'd0;
    localparam logic [1:0]  PORT_LOAD  = 2'd1;
    localparam logic [1:0]  PORT_STORE = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE_TAG,
        ISSUE,
        WAIT_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [1:0]             size_q, size_d;
    logic [63:0]            wdata_q, wdata_d;
    logic [7:0]             be_q, be_d;
    logic                   we_q, we_d;
    logic [7:0]             starve_q, starve_d;
    logic                   ack_done_q, ack_done_d;

    logic [2:0]             gnt;
    logic                   flush_ack;
    logic [2:0]             rvalid;
    logic [63:0]            rdata;
    logic                   mem_req;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        index_d    = index_q;
        tag_d      = tag_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        starve_d   = starve_q;
        ack_done_d = ack_done_q && bus.flush_i;
        gnt        = '0;
        flush_ack  = 1'b0;
        rvalid     = '0;
        rdata      = '0;
        mem_req    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    if (!ack_done_q) begin
                        flush_ack  = 1'b1;
                        ack_done_d = 1'b1;
                    end
                end else if (bus.req_i[2] && starve_q == STARVE_MAX) begin
                    gnt = 3'b100;
                end else if (bus.req_i[0]) begin
                    gnt = 3'b001;
                end else if (bus.req_i[1]) begin
                    gnt = 3'b010;
                end else if (bus.req_i[2]) begin
                    gnt = 3'b100;
                end

                if (gnt[2]) begin
                    owner_d = PORT_STORE;
                    index_d = bus.index_i[2];
                    tag_d   = bus.tag_i[2];
                    size_d  = bus.size_i[2];
                    wdata_d = bus.st_wdata_i;
                    be_d    = bus.st_be_i;
                    we_d    = 1'b1;
                    state_d = ISSUE;
                end else if (gnt[1:0] != 2'b00) begin
                    owner_d = gnt[0] ? PORT_PTW : PORT_LOAD;
                    index_d = bus.index_i[gnt[0] ? 0 : 1];
                    size_d  = bus.size_i[gnt[0] ? 0 : 1];
                    wdata_d = '0;
                    be_d    = '0;
                    we_d    = 1'b0;
                    state_d = SAMPLE_TAG;
                end

                // A pending store only ages while it actually loses to another port.
                if (!bus.req_i[2] || gnt[2]) begin
                    starve_d = '0;
                end else if (gnt[1:0] != 2'b00 && starve_q < STARVE_MAX) begin
                    starve_d = starve_q + 8'd1;
                end
            end

            SAMPLE_TAG: begin
                tag_d = bus.tag_i[owner_q];
                if (bus.kill_i[owner_q]) begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                mem_req = 1'b1;
                if (bus.mem_gnt_i) begin
                    state_d = WAIT_RESP;
                end
            end

            WAIT_RESP: begin
                if (bus.mem_rvalid_i) begin
                    rvalid[owner_q] = 1'b1;
                    rdata           = we_q ? 64'd0 : bus.mem_rdata_i;
                    state_d         = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            index_q    <= '0;
            tag_q      <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            starve_q   <= '0;
            ack_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            index_q    <= index_d;
            tag_q      <= tag_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            starve_q   <= starve_d;
            ack_done_q <= ack_done_d;
        end
    end

    // Idle outputs follow the request inputs combinationally; keep them quiet
    // while reset is held so every output reads 0 during reset.
    assign bus.gnt_o       = rst_ni ? gnt : 3'b000;
    assign bus.flush_ack_o = rst_ni && flush_ack;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.rvalid_o    = rvalid;
    assign bus.rdata_o     = rdata;

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = {{PAD_WIDTH{1'b0}}, tag_q, index_q};
    assign bus.mem_size_o  = size_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_be_o    = be_q;

    // Handshake invariants the surrounding cache relies on.
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.gnt_o));
    a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.rvalid_o));
    a_no_gnt_with_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.flush_ack_o && bus.gnt_o != 3'b000));
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.mem_req_o && !bus.mem_gnt_i |=> bus.mem_req_o
            && $stable(bus.mem_addr_o) && $stable(bus.mem_we_o)
            && $stable(bus.mem_wdata_o) && $stable(bus.mem_be_o)
            && $stable(bus.mem_size_o));
endmodule

// File: tb/tb_dcache_bypass_arbiter.sv
// Directed bench for dcache_bypass_arbiter: load, priority, kill, store
// starvation, flush drain, memory backpressure and asynchronous reset.
module tb_dcache_bypass_arbiter;
    localparam int unsigned IW = 12;
    localparam int unsigned TW = 44;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    dcache_bypass_arbiter_if #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

    dcache_bypass_arbiter #(
        .INDEX_WIDTH (IW),
        .TAG_WIDTH   (TW),
        .STARVE_LIMIT(3)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are sampled 1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.flush_i      = 1'b1;
        bus.req_i        = 3'b111;
        bus.index_i      = '0;
        bus.tag_i        = '0;
        bus.kill_i       = '0;
        bus.size_i       = '0;
        bus.st_wdata_i   = '0;
        bus.st_be_i      = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        #3;
        check("rst_gnt", 64'(bus.gnt_o), 64'h0);
        check("rst_flush_ack", 64'(bus.flush_ack_o), 64'h0);
        check("rst_busy", 64'(bus.busy_o), 64'h0);
        check("rst_mem_req", 64'(bus.mem_req_o), 64'h0);
        check("rst_mem_addr", bus.mem_addr_o, 64'h0);
        check("rst_rvalid", 64'(bus.rvalid_o), 64'h0);

        repeat (2) @(posedge clk);
        #2;
        rst_n       = 1'b1;
        bus.req_i   = 3'b000;
        bus.flush_i = 1'b0;
        settle();
        check("post_rst_idle", 64'(bus.gnt_o), 64'h0);

        // Load without kill against zero-wait memory.
        tick();
        bus.req_i      = 3'b010;
        bus.index_i[1] = 12'h123;
        bus.size_i[1]  = 2'b11;
        settle();
        check("ld_gnt_c0", 64'(bus.gnt_o), 64'h2);
        check("ld_busy_c0", 64'(bus.busy_o), 64'h0);
        tick();
        bus.req_i    = 3'b000;
        bus.tag_i[1] = 44'hABC;
        settle();
        check("ld_busy_c1", 64'(bus.busy_o), 64'h1);
        check("ld_memreq_c1", 64'(bus.mem_req_o), 64'h0);
        tick();
        bus.mem_gnt_i = 1'b1;
        settle();
        check("ld_memreq_c2", 64'(bus.mem_req_o), 64'h1);
        check("ld_addr_c2", bus.mem_addr_o, 64'hABC123);
        check("ld_we_c2", 64'(bus.mem_we_o), 64'h0);
        check("ld_size_c2", 64'(bus.mem_size_o), 64'h3);
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hDEAD_BEEF;
        settle();
        check("ld_rvalid_c3", 64'(bus.rvalid_o), 64'h2);
        check("ld_rdata_c3", bus.rdata_o, 64'hDEAD_BEEF);
        tick();
        bus.mem_rvalid_i = 1'b0;
        settle();
        check("ld_busy_c4", 64'(bus.busy_o), 64'h0);
        check("ld_rvalid_c4", 64'(bus.rvalid_o), 64'h0);

        // PTW and LOAD together: PTW first, LOAD right after PTW's response.
        tick();
        bus.req_i      = 3'b011;
        bus.index_i[0] = 12'h010;
        bus.index_i[1] = 12'h020;
        settle();
        check("pri_gnt_ptw", 64'(bus.gnt_o), 64'h1);
        tick();
        bus.tag_i[0] = 44'h5;
        settle();
        check("pri_no_gnt_busy", 64'(bus.gnt_o), 64'h0);
        tick();
        bus.mem_gnt_i = 1'b1;
        settle();
        check("pri_ptw_addr", bus.mem_addr_o, 64'h5010);
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h1111;
        bus.req_i        = 3'b010;
        settle();
        check("pri_ptw_rvalid", 64'(bus.rvalid_o), 64'h1);
        check("pri_ptw_rdata", bus.rdata_o, 64'h1111);
        tick();
        bus.mem_rvalid_i = 1'b0;
        settle();
        check("pri_gnt_load", 64'(bus.gnt_o), 64'h2);
        tick();
        bus.req_i    = 3'b000;
        bus.tag_i[1] = 44'h6;
        tick();
        bus.mem_gnt_i = 1'b1;
        settle();
        check("pri_load_addr", bus.mem_addr_o, 64'h6020);
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h2222;
        settle();
        check("pri_load_rvalid", 64'(bus.rvalid_o), 64'h2);
        check("pri_load_rdata", bus.rdata_o, 64'h2222);
        tick();
        bus.mem_rvalid_i = 1'b0;

        // Kill in the tag cycle: immediate zero response, no memory access.
        bus.req_i      = 3'b010;
        bus.index_i[1] = 12'h0AA;
        settle();
        check("kill_gnt", 64'(bus.gnt_o), 64'h2);
        tick();
        bus.req_i       = 3'b000;
        bus.kill_i      = 3'b010;
        bus.tag_i[1]    = 44'h7;
        bus.mem_rdata_i = 64'hFFFF;
        settle();
        check("kill_rvalid", 64'(bus.rvalid_o), 64'h2);
        check("kill_rdata", bus.rdata_o, 64'h0);
        check("kill_memreq_tag", 64'(bus.mem_req_o), 64'h0);
        tick();
        bus.kill_i = 3'b000;
        settle();
        check("kill_idle", 64'(bus.busy_o), 64'h0);
        check("kill_memreq_after", 64'(bus.mem_req_o), 64'h0);

        // Store starvation with limit 3: three killed loads win, then the store.
        tick();
        bus.req_i       = 3'b110;
        bus.kill_i      = 3'b010;
        bus.index_i[2]  = 12'h008;
        bus.tag_i[2]    = 44'h1;
        bus.size_i[2]   = 2'b11;
        bus.st_be_i     = 8'h0F;
        bus.st_wdata_i  = 64'h55;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("starve_load_gnt%0d", i), 64'(bus.gnt_o), 64'h2);
            tick();
            settle();
            check($sformatf("starve_kill_rv%0d", i), 64'(bus.rvalid_o), 64'h2);
            tick();
        end
        settle();
        check("starve_store_gnt", 64'(bus.gnt_o), 64'h4);
        tick();
        bus.req_i     = 3'b000;
        bus.kill_i    = 3'b111;
        bus.mem_gnt_i = 1'b1;
        settle();
        check("st_memreq", 64'(bus.mem_req_o), 64'h1);
        check("st_we", 64'(bus.mem_we_o), 64'h1);
        check("st_addr", bus.mem_addr_o, 64'h1008);
        check("st_be", 64'(bus.mem_be_o), 64'h0F);
        check("st_wdata", bus.mem_wdata_o, 64'h55);
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h9999;
        settle();
        check("st_rvalid", 64'(bus.rvalid_o), 64'h4);
        check("st_rdata_zero", bus.rdata_o, 64'h0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.kill_i       = 3'b000;

        // Flush raised during an outstanding load.
        bus.req_i      = 3'b010;
        bus.index_i[1] = 12'h0BB;
        settle();
        check("fl_gnt_load", 64'(bus.gnt_o), 64'h2);
        tick();
        bus.flush_i  = 1'b1;
        bus.req_i    = 3'b011;
        bus.tag_i[1] = 44'h9;
        settle();
        check("fl_no_ack_tag", 64'(bus.flush_ack_o), 64'h0);
        tick();
        bus.mem_gnt_i = 1'b1;
        settle();
        check("fl_no_ack_issue", 64'(bus.flush_ack_o), 64'h0);
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h3333;
        settle();
        check("fl_load_rvalid", 64'(bus.rvalid_o), 64'h2);
        check("fl_load_rdata", bus.rdata_o, 64'h3333);
        check("fl_no_ack_resp", 64'(bus.flush_ack_o), 64'h0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        settle();
        check("fl_ack", 64'(bus.flush_ack_o), 64'h1);
        check("fl_no_gnt_ack", 64'(bus.gnt_o), 64'h0);
        tick();
        settle();
        check("fl_ack_once", 64'(bus.flush_ack_o), 64'h0);
        check("fl_no_gnt_held", 64'(bus.gnt_o), 64'h0);
        tick();
        bus.flush_i = 1'b0;
        settle();
        check("fl_gnt_resume", 64'(bus.gnt_o), 64'h1);
        tick();
        bus.req_i    = 3'b000;
        bus.tag_i[0] = 44'h3;
        tick();
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h4444;
        settle();
        check("fl_ptw_rvalid", 64'(bus.rvalid_o), 64'h1);
        tick();
        bus.mem_rvalid_i = 1'b0;

        // Memory backpressure on a store, then reset while waiting for the response.
        bus.req_i      = 3'b100;
        bus.index_i[2] = 12'h034;
        bus.tag_i[2]   = 44'h2;
        bus.size_i[2]  = 2'b01;
        bus.st_wdata_i = 64'hA5A5;
        bus.st_be_i    = 8'hF0;
        settle();
        check("bp_gnt", 64'(bus.gnt_o), 64'h4);
        tick();
        bus.req_i = 3'b000;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("bp_memreq%0d", i), 64'(bus.mem_req_o), 64'h1);
            check($sformatf("bp_addr%0d", i), bus.mem_addr_o, 64'h2034);
            check($sformatf("bp_wdata%0d", i), bus.mem_wdata_o, 64'hA5A5);
            check($sformatf("bp_be%0d", i), 64'(bus.mem_be_o), 64'hF0);
            check($sformatf("bp_size%0d", i), 64'(bus.mem_size_o), 64'h1);
            tick();
        end
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        settle();
        check("rs_busy_wait", 64'(bus.busy_o), 64'h1);
        check("rs_no_rvalid_wait", 64'(bus.rvalid_o), 64'h0);
        rst_n            = 1'b0;
        bus.req_i        = 3'b111;
        bus.flush_i      = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        settle();
        check("rs_busy", 64'(bus.busy_o), 64'h0);
        check("rs_rvalid", 64'(bus.rvalid_o), 64'h0);
        check("rs_gnt", 64'(bus.gnt_o), 64'h0);
        check("rs_flush_ack", 64'(bus.flush_ack_o), 64'h0);
        check("rs_memreq", 64'(bus.mem_req_o), 64'h0);
        check("rs_we", 64'(bus.mem_we_o), 64'h0);
        check("rs_addr", bus.mem_addr_o, 64'h0);
        check("rs_wdata", bus.mem_wdata_o, 64'h0);
        tick();
        rst_n       = 1'b1;
        bus.req_i   = 3'b000;
        bus.flush_i = 1'b0;
        settle();
        check("rs_rvalid_ignored", 64'(bus.rvalid_o), 64'h0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.req_i        = 3'b010;
        settle();
        check("rs_recover_gnt", 64'(bus.gnt_o), 64'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_bypass_arbiter.md
Name: dcache_bypass_arbiter

Overview:
- Shares one single-outstanding memory request port between the three data-cache request ports: PTW (0), LOAD (1) and STORE (2).
- Sits in the cache subsystem in front of the uncached/bypass AXI adapter and sequences each access through grant, tag sampling, issue and response.
- Uses fixed priority PTW > LOAD > STORE, with an anti-starvation override for STORE.
- Also handles kill requests and flush drain/acknowledge.

Parameters:
- INDEX_WIDTH, 12, width of the address index sent with the request.
- TAG_WIDTH, 44, width of the address tag sent one cycle after grant (loads/PTW) or with the request (store).
- STARVE_LIMIT, 15, number of lost arbitration cycles after which a pending STORE wins; 1..255.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  flush request, held high until acknowledged
- flush_ack_o  out  1  one-cycle flush acknowledge
- busy_o  out  1  transaction in flight (state != Idle)
- req_i  in  3  per-port request
- index_i  in  3xINDEX_WIDTH  per-port address index
- tag_i  in  3xTAG_WIDTH  per-port address tag
- kill_i  in  3  per-port kill, valid in the tag cycle
- size_i  in  3x2  per-port access size (log2 bytes)
- st_wdata_i  in  64  store data (port 2 only)
- st_be_i  in  8  store byte enables
- gnt_o  out  3  per-port grant (one-hot or zero)
- rvalid_o  out  3  per-port response valid (one-hot or zero)
- rdata_o  out  64  response data, shared by all ports
- mem_req_o  out  1  memory request valid
- mem_gnt_i  in  1  memory request accepted
- mem_we_o  out  1  write when 1
- mem_addr_o  out  64  {zero pad, tag, index}
- mem_size_o  out  2  access size
- mem_wdata_o  out  64  write data
- mem_be_o  out  8  byte enables
- mem_rvalid_i  in  1  response valid (read data or write completion)
- mem_rdata_i  in  64  read data

Behaviour:
- Reset: state Idle, starve_cnt 0, all registers 0, every output 0.
- States: Idle, SampleTag, Issue, WaitResp.
- Idle, flush_i high:
  - No grant is given.
  - flush_ack_o=1 for exactly one cycle.
  - An ack_done flag then blocks further acks until flush_i drops.
- Idle, flush_i low, arbitration (combinational gnt_o in the same cycle as req_i):
  - If req_i[2] and starve_cnt==STARVE_LIMIT, grant STORE.
  - Otherwise grant PTW > LOAD > STORE.
- LOAD/PTW grant: register owner, index and size; go to SampleTag.
- STORE grant: register the full address {tag_i[2], index_i[2]}, size, wdata and be; set we=1; go to Issue.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, in any Idle cycle where req_i[2]=1 and another port is granted.
  - Clears when STORE is granted or when req_i[2]=0.
  - Holds in all other states.
- SampleTag:
  - Register tag_i[owner].
  - If kill_i[owner]: rvalid_o[owner]=1, rdata_o=0, no memory access, go to Idle.
  - Otherwise go to Issue.
- Issue: mem_req_o=1 with the registered fields, held stable until mem_gnt_i; then go to WaitResp.
- WaitResp: on mem_rvalid_i, rvalid_o[owner]=1 for one cycle, then go to Idle.
  - Read: rdata_o=mem_rdata_i.
  - Write: rdata_o=0.
- kill_i outside SampleTag is ignored; an issued access always completes.
- mem_rvalid_i outside WaitResp is ignored.
- mem_addr_o upper 64-TAG_WIDTH-INDEX_WIDTH bits are 0.
- Minimum latency from memory: zero-wait-state memory means mem_gnt_i in the first Issue cycle and mem_rvalid_i one cycle later.
- Latencies against a zero-wait-state memory, counting the grant cycle as cycle 0:
  - Load: rvalid at cycle 3; the next grant is possible at cycle 4.
  - Store: rvalid at cycle 2.
- flush_i raised mid-transaction: the current transaction completes, then the ack is given in Idle; no new grant in between.
- Reset asserted mid-operation: abandon immediately, return to reset state, no response emitted.

Test Plan:
- Load, no kill: req_i=010, index 0x123, tag 0xABC next cycle, zero-wait memory returning 0xDEAD_BEEF. Required: gnt_o=010 at cycle 0; mem_addr_o=0xABC123 at cycle 2; rvalid_o=010 with rdata_o=0xDEAD_BEEF at cycle 3.
- PTW and LOAD request together: PTW granted first. LOAD granted in the Idle cycle after the PTW rvalid. Responses are one-hot to the correct port.
- Kill: LOAD granted, kill_i[1]=1 in the tag cycle. Required: rvalid_o=010 with rdata_o=0 the next cycle, and no mem_req_o pulse.
- Store starvation: STARVE_LIMIT=3, LOAD requesting continuously, STORE pending (tag 0x1, index 0x8, be 0x0F, wdata 0x55). Required: STORE granted after 3 lost Idle cycles; mem_we_o=1, mem_addr_o=0x1008, mem_be_o=0x0F.
- Flush during an outstanding load: no grant until the load's rvalid. Then flush_ack_o is high for exactly one cycle while flush_i stays high, and grants resume after flush_i drops.
- Memory backpressure and reset: hold mem_gnt_i=0 for 5 cycles; mem_req_o and all mem_* fields stay stable. Assert rst_ni=0 in WaitResp; all outputs go to 0 and busy_o=0 asynchronously.
